rr_arb_mux: RTL and testbench
=============================

// Module: rr_arb_mux
// PURPOSE
//  Registered N-channel arbitrating multiplexer; successor to the one-hot parallel mux.
//  Each channel offers data with a valid/ready handshake, and an arbiter picks one per cycle.
//  The winner is captured into a single-entry output register with valid/ready toward the consumer.
//  Used where several pipeline sources share one sink (e.g. write-back or memory-request ports).
// PARAMETERS
//  WIDTH         32  data width per channel, >=1
//  MUX_QUANTITY  4   number of input channels, >=1
//  FIXED_PRIO    0   0 = round-robin arbitration; 1 = fixed priority (channel 0 highest)
// PORTS
//  clk        in   1                   clock, all state on rising edge
//  rst        in   1                   reset, asynchronous, active-high
//  in_valid   in   MUX_QUANTITY        per-channel request
//  in_data    in   WIDTH*MUX_QUANTITY  channel i occupies bits [WIDTH*i +: WIDTH]
//  in_ready   out  MUX_QUANTITY        per-channel accept; one-hot or zero
//  out_valid  out  1                   output register holds a beat
//  out_data   out  WIDTH               held beat data
//  out_sel    out  MUX_QUANTITY        one-hot source channel of held beat
//  out_ready  in   1                   consumer accepts held beat
// BEHAVIOUR
//  - Reset (async, while rst=1): out_valid=0, out_data=0, out_sel=0, rr pointer=0.
//    in_ready is forced to 0 during reset. A beat held when reset asserts is dropped.
//  - Load condition: load_en = ~out_valid | out_ready.
//  - Grant: a combinational one-hot vector over in_valid.
//    - RR: search from pointer p upward with wrap-around (p, p+1, ..., N-1, 0, ..., p-1).
//      The first valid channel wins.
//    - FIXED_PRIO=1: the lowest-index valid channel wins, and the pointer is ignored.
//  - in_ready[i] = grant[i] & load_en. At most one bit is set.
//    A transfer on channel i occurs when in_valid[i] & in_ready[i].
//  - in_ready may depend combinationally on in_valid and out_ready.
//    Producers must not make in_valid depend on in_ready.
//  - On a rising edge with a transfer on channel g:
//    out_valid<=1, out_data<=in_data[g], out_sel<=onehot(g), and p<=(g+1) mod N.
//  - On a rising edge with load_en but no transfer: out_valid<=0.
//    out_data and out_sel keep their old values (don't-care).
//  - When out_valid & ~out_ready, out_valid, out_data and out_sel are held stable.
//    All in_ready are 0 and p is unchanged.
//  - Simultaneous drain and refill: when out_ready=1 and a transfer occurs in the same cycle,
//    the new beat replaces the old one with no bubble. Full throughput is 1 beat/cycle.
//  - Latency: a beat accepted at edge k is visible on out_* after edge k and leaves no earlier than edge k+1.
//  - The pointer advances only on a transfer. An idle cycle leaves p unchanged.
//  - Starvation bound (RR): a continuously-valid channel is granted within N transfers.
//  - MUX_QUANTITY=1: the grant is in_valid[0], and the block degenerates to a one-entry pipeline register.
//  - The grant encode and data select use an AND-OR structure over the one-hot grant.
//    There is no priority encoder on the data path. out_data is never X after reset.
// TESTING
//  1. Reset mid-beat: load ch2=0xA5, hold out_ready=0, pulse rst.
//     -> out_valid=0, out_data=0, out_sel=0 immediately; the next grant starts at ch0.
//  2. RR fairness, N=4, all in_valid=1, out_ready=1 for 8 cycles.
//     -> out_sel sequence 0001,0010,0100,1000,0001,... with one beat every cycle.
//  3. Backpressure: ch1 valid with 0x1234, out_ready=0 for 3 cycles.
//     -> out_data=0x1234 is stable; in_ready=0000 until out_ready=1, then ch1 may reload.
//  4. Fixed priority (FIXED_PRIO=1): ch3 and ch1 both valid continuously.
//     -> ch1 always wins and ch3 is never granted.
//  5. Pointer hold: grant ch2, idle 5 cycles, then ch0 and ch3 request.
//     -> ch3 is granted first (p=3).
//  6. Drain-and-refill: out_valid=1, out_ready=1, ch0 valid with 0xFF in the same cycle.
//     -> out_valid stays 1 and out_data becomes 0xFF with no bubble.

Source files
------------

// File: rtl/rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : rr_arb_mux
// Brief    : N-channel valid/ready arbitrating mux (round-robin or fixed
//            priority) feeding a single-entry registered output stage.
// Revision : 1.0 - initial release
// ============================================================================
module rr_arb_mux #(
    parameter int WIDTH        = 32,
    parameter int MUX_QUANTITY = 4,
    parameter int FIXED_PRIO   = 0
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [MUX_QUANTITY-1:0]         in_valid,
    input  logic [WIDTH*MUX_QUANTITY-1:0]   in_data,
    output logic [MUX_QUANTITY-1:0]         in_ready,
    output logic                            out_valid,
    output logic [WIDTH-1:0]                out_data,
    output logic [MUX_QUANTITY-1:0]         out_sel,
    input  logic                            out_ready
);

    localparam int c_PTR_W = (MUX_QUANTITY > 1) ? $clog2(MUX_QUANTITY) : 1;

    logic                      r_valid;
    logic [WIDTH-1:0]          r_data;
    logic [MUX_QUANTITY-1:0]   r_sel;
    logic [c_PTR_W-1:0]        r_ptr;

    logic [c_PTR_W-1:0]        w_start;
    logic [MUX_QUANTITY-1:0]   w_grant;
    logic                      w_found;
    logic [c_PTR_W-1:0]        w_gidx;
    logic [c_PTR_W-1:0]        w_ptr_nxt;
    logic [WIDTH-1:0]          w_mux;
    logic                      w_load;
    logic                      w_xfer;

    assign w_start = (FIXED_PRIO != 0) ? '0 : r_ptr;

    // Search offsets 0..N-1 from the start channel; the first requester wins.
    always_comb begin
        w_grant = '0;
        w_found = 1'b0;
        for (int k = 0; k < MUX_QUANTITY; k++) begin
            for (int i = 0; i < MUX_QUANTITY; i++) begin
                if (!w_found && in_valid[i] &&
                    (i == ((int'(w_start) + k) % MUX_QUANTITY))) begin
                    w_grant[i] = 1'b1;
                    w_found    = 1'b1;
                end
            end
        end
    end

    always_comb begin
        w_gidx = '0;
        w_mux  = '0;
        for (int i = 0; i < MUX_QUANTITY; i++) begin
            if (w_grant[i]) begin
                w_gidx = w_gidx | c_PTR_W'(i);
            end
            w_mux = w_mux | ({WIDTH{w_grant[i]}} & in_data[WIDTH*i +: WIDTH]);
        end
    end

    assign w_ptr_nxt = (w_gidx == c_PTR_W'(MUX_QUANTITY - 1)) ? '0
                                                               : w_gidx + c_PTR_W'(1);

    assign w_load   = ~r_valid | out_ready;
    assign in_ready = w_grant & {MUX_QUANTITY{w_load & ~rst}};
    assign w_xfer   = |in_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_sel   <= '0;
            r_ptr   <= '0;
        end else if (w_load) begin
            r_valid <= w_xfer;
            if (w_xfer) begin
                r_data <= w_mux;
                r_sel  <= w_grant;
                r_ptr  <= w_ptr_nxt;
            end
        end
    end

    assign out_valid = r_valid;
    assign out_data  = r_data;
    assign out_sel   = r_sel;

endmodule
`default_nettype wire

// File: tb/tb_rr_arb_mux.sv
`default_nettype none
// ============================================================================
// Module   : tb_rr_arb_mux
// Brief    : Self-checking bench for rr_arb_mux (RR and fixed-priority builds).
// Revision : 1.0 - initial release
// ============================================================================
module tb_rr_arb_mux;

    localparam int N = 4;
    localparam int W = 32;

    logic             clk;
    logic             rst;
    logic [N-1:0]     in_valid;
    logic [W*N-1:0]   in_data;
    logic             out_ready;

    logic [N-1:0]     rr_in_ready, fp_in_ready;
    logic             rr_out_valid, fp_out_valid;
    logic [W-1:0]     rr_out_data, fp_out_data;
    logic [N-1:0]     rr_out_sel, fp_out_sel;

    int total = 0;
    int bad   = 0;

    rr_arb_mux #(.WIDTH(W), .MUX_QUANTITY(N), .FIXED_PRIO(0)) u_rr (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(rr_in_ready), .out_valid(rr_out_valid), .out_data(rr_out_data),
        .out_sel(rr_out_sel), .out_ready(out_ready)
    );

    rr_arb_mux #(.WIDTH(W), .MUX_QUANTITY(N), .FIXED_PRIO(1)) u_fp (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data),
        .in_ready(fp_in_ready), .out_valid(fp_out_valid), .out_data(fp_out_data),
        .out_sel(fp_out_sel), .out_ready(out_ready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model state, index 0 = round-robin build, 1 = fixed priority.
    logic        mv[2];
    logic [W-1:0] md[2];
    logic [N-1:0] ms[2];
    int           mp[2];
    int           win[2];
    logic         mload[2];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            mv[m] = 1'b0;
            md[m] = '0;
            ms[m] = '0;
            mp[m] = 0;
        end
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) in_data[W*i +: W] = $urandom;
    endtask

    // Compare both DUTs against the model, then clock once and advance the model.
    task automatic step();
        logic [N-1:0] er;
        int start;
        #2;
        for (int m = 0; m < 2; m++) begin
            mload[m] = !mv[m] || out_ready;
            win[m]   = -1;
            if (mload[m]) begin
                start = (m == 1) ? 0 : mp[m];
                for (int off = 0; off < N; off++) begin
                    if (win[m] < 0 && in_valid[(start + off) % N]) win[m] = (start + off) % N;
                end
            end
            er = (win[m] >= 0) ? N'(1 << win[m]) : '0;
            if (m == 0) begin
                chk("rr_in_ready", rr_in_ready, er);
                chk("rr_out_valid", rr_out_valid, mv[m]);
                chk("rr_out_data", rr_out_data, md[m]);
                chk("rr_out_sel", rr_out_sel, ms[m]);
            end else begin
                chk("fp_in_ready", fp_in_ready, er);
                chk("fp_out_valid", fp_out_valid, mv[m]);
                chk("fp_out_data", fp_out_data, md[m]);
                chk("fp_out_sel", fp_out_sel, ms[m]);
            end
        end
        @(posedge clk);
        for (int m = 0; m < 2; m++) begin
            if (mload[m]) begin
                mv[m] = (win[m] >= 0);
                if (win[m] >= 0) begin
                    md[m] = in_data[W*win[m] +: W];
                    ms[m] = N'(1 << win[m]);
                    mp[m] = (win[m] + 1) % N;
                end
            end
        end
        #1;
    endtask

    typedef struct {
        logic [N-1:0] vld;
        logic         rdy;
        logic [N-1:0] exp_rdy;
        logic         exp_ov;
        logic [N-1:0] exp_sel;
    } vec_t;

    vec_t tbl[14];

    initial begin
        // Round-robin build, starting from reset (pointer 0).
        tbl[0]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[1]  = '{4'b1111, 1'b1, 4'b0010, 1'b1, 4'b0010};
        tbl[2]  = '{4'b1111, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[3]  = '{4'b1111, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[4]  = '{4'b1111, 1'b1, 4'b0001, 1'b1, 4'b0001};
        tbl[5]  = '{4'b0100, 1'b1, 4'b0100, 1'b1, 4'b0100};
        tbl[6]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100};
        tbl[7]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100};
        tbl[8]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100};
        tbl[9]  = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100};
        tbl[10] = '{4'b0000, 1'b1, 4'b0000, 1'b0, 4'b0100};
        tbl[11] = '{4'b1001, 1'b1, 4'b1000, 1'b1, 4'b1000};
        tbl[12] = '{4'b1001, 1'b0, 4'b0000, 1'b1, 4'b1000};
        tbl[13] = '{4'b1001, 1'b1, 4'b0001, 1'b1, 4'b0001};

        rst       = 1'b1;
        in_valid  = '0;
        in_data   = '0;
        out_ready = 1'b0;
        model_reset();
        #2;
        chk("reset_out_valid", rr_out_valid, 1'b0);
        chk("reset_out_data", rr_out_data, '0);
        chk("reset_out_sel", rr_out_sel, '0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            in_valid  = tbl[i].vld;
            out_ready = tbl[i].rdy;
            rand_data();
            #1;
            chk($sformatf("tbl%0d_in_ready", i), rr_in_ready, tbl[i].exp_rdy);
            step();
            chk($sformatf("tbl%0d_out_valid", i), rr_out_valid, tbl[i].exp_ov);
            chk($sformatf("tbl%0d_out_sel", i), rr_out_sel, tbl[i].exp_sel);
        end

        // Drain and refill in the same cycle: no bubble.
        in_valid  = 4'b0001;
        in_data[0 +: W] = 32'h0000_00FF;
        out_ready = 1'b1;
        #1;
        step();
        chk("refill_out_valid", rr_out_valid, 1'b1);
        chk("refill_out_data", rr_out_data, 32'h0000_00FF);

        // Backpressure: held beat must stay stable while the consumer stalls.
        in_valid  = 4'b0010;
        in_data[W +: W] = 32'h0000_1234;
        step();
        in_data[W +: W] = 32'h0000_9999;
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("bp_in_ready", rr_in_ready, 4'b0000);
            step();
            chk("bp_out_data", rr_out_data, 32'h0000_1234);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release_in_ready", rr_in_ready, 4'b0010);
        step();

        // Fixed priority: ch1 beats ch3 every time.
        in_valid = 4'b1010;
        for (int c = 0; c < 6; c++) begin
            rand_data();
            #1;
            chk("fp_grant", fp_in_ready, 4'b0010);
            step();
            chk("fp_sel", fp_out_sel, 4'b0010);
        end

        // Reset while a beat is held: it is dropped and arbitration restarts at ch0.
        in_valid  = 4'b0100;
        in_data[2*W +: W] = 32'h0000_00A5;
        step();
        in_valid  = 4'b0000;
        out_ready = 1'b0;
        step();
        chk("mid_held_data", rr_out_data, 32'h0000_00A5);
        #1;
        rst      = 1'b1;
        in_valid = 4'b1111;
        #1;
        chk("mid_rst_out_valid", rr_out_valid, 1'b0);
        chk("mid_rst_out_data", rr_out_data, '0);
        chk("mid_rst_out_sel", rr_out_sel, '0);
        chk("mid_rst_in_ready", rr_in_ready, '0);
        chk("mid_rst_fp_in_ready", fp_in_ready, '0);
        model_reset();
        @(posedge clk);
        #1;
        rst       = 1'b0;
        out_ready = 1'b1;
        #1;
        chk("post_rst_grant", rr_in_ready, 4'b0001);
        step();

        // Randomized traffic against the reference model.
        for (int c = 0; c < 3000; c++) begin
            in_valid  = N'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            rand_data();
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
